aes_enc_arbiter: RTL and testbench
==================================

Name: aes_enc_arbiter

Overview:
- Shares one top_encryption core between two requesters (port 0, port 1) with round-robin arbitration.
- Captures the winning requester's plaintext/key, pulses core start, waits for done, and returns the ciphertext to that requester over a valid/ready response channel.
- Watchdog aborts a job whose done never arrives.
- Sits between the system-side request masters and the encryption core.

Parameters:
- TIMEOUT_CYCLES, 64, cycles in WAIT without core_done before abort (must be >= 2).
- CNT_W, 8, width of the watchdog counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  port 0 job request.
- req0_ready  output  1  port 0 job accepted this cycle.
- req0_plaintext  input  128  port 0 plaintext.
- req0_key  input  128  port 0 key.
- req1_valid, req1_ready, req1_plaintext, req1_key  as port 0, for port 1.
- rsp0_valid  output  1  port 0 result available.
- rsp0_ready  input  1  port 0 consumes result.
- rsp0_err  output  1  qualifies rsp0_valid; 1 = timed out, data is zero.
- rsp1_valid, rsp1_ready, rsp1_err  as port 0, for port 1.
- rsp_data  output  128  ciphertext, shared by both response ports.
- core_start  output  1  one-cycle start pulse to the core.
- core_plaintext  output  128  registered plaintext to the core.
- core_key  output  128  registered key to the core.
- core_done  input  1  core completion.
- core_ciphertext  input  128  core result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- States: IDLE, LAUNCH, WAIT, RESP.
- Reset (reset=0, async) values:
  - State IDLE.
  - All ready/valid/err/core_start/busy outputs 0.
  - rsp_data, core_plaintext, core_key all 0.
  - last_served = 1, so port 0 wins the first tie.
  - Watchdog = 0.
- Reset mid-job abandons the job; no response is issued.

Grant (combinational, IDLE only):
- Only one valid: that port.
- Both valid: the port != last_served.
- reqN_ready = (state==IDLE) & grant==N; at most one ready is high per cycle.
- Ready never asserts outside IDLE.

Job flow:
- IDLE -> LAUNCH on a handshake at cycle T.
- At T+1:
  - Plaintext/key are registered into core_plaintext/core_key.
  - owner and last_served are set to the granted port.
- LAUNCH (cycle T+1): core_start=1 for exactly this one cycle; -> WAIT.
- core_plaintext/core_key stay stable from LAUNCH until the state returns to IDLE.
- WAIT: watchdog increments each cycle, starting from 0 on entry.
  - If core_done=1: latch core_ciphertext into rsp_data, set err=0, -> RESP.
  - Else if watchdog == TIMEOUT_CYCLES-1: set rsp_data=0, err=1, -> RESP.
  - core_done takes priority over timeout in the same cycle.
- core_done is ignored in IDLE, LAUNCH and RESP; a stray done has no effect.
- RESP:
  - rsp<owner>_valid=1 and rsp<owner>_err = latched err; the other port's valid stays 0.
  - rsp_data is held stable until the handshake.
  - On rsp<owner>_ready=1: -> IDLE.
  - A new grant is possible in the cycle after the handshake, not the same cycle.
- Minimum request-to-response: rsp_valid is high at D+1 when core_done is seen at D.
- Requests held valid while busy are not lost; they are granted on the return to IDLE.
- busy = (state != IDLE).

Test Plan:
- FIPS-197 vector, bench core model with 11-cycle done latency:
  - Stimulus: port 0, plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: core_start is a single pulse at T+1; rsp0_valid with rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a; rsp0_err=0; rsp1_valid stays 0.
- Both ports valid continuously for 4 jobs, rsp_ready tied 1 -> grant order 0,1,0,1; each port's rsp carries its own vector's ciphertext.
- Port 1 asserts valid during port 0's WAIT -> req1_ready stays 0 until IDLE; port 1 is granted in the cycle after port 0's rsp handshake.
- Core model never asserts done, TIMEOUT_CYCLES=64 -> rsp0_valid with rsp0_err=1 and rsp_data=0 exactly 64 cycles after WAIT entry; the next job then completes normally.
- rsp0_ready held 0 for 20 cycles in RESP -> rsp_data and rsp0_valid stay stable; no new ready; core_start is not re-pulsed.
- reset pulled low during WAIT, then released -> all outputs 0 immediately (asynchronous); late core_done is ignored; next tie grants port 0.

Source files
------------

// File: rtl/aes_enc_arbiter.sv
// Two-port round-robin front end for a single encryption core.
// Captures the granted job, pulses the core, waits for done (with a watchdog)
// and hands the ciphertext back to the owning port over a valid/ready channel.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no job; grant is combinational, one ready may assert
// LAUNCH | job registered; core_start high for this single cycle
// WAIT   | waiting for core_done; watchdog counts up from 0
// RESP   | result (or timeout error) presented to owner port
module aes_enc_arbiter #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [127:0] req0_plaintext,
   input  logic [127:0] req0_key,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [127:0] req1_plaintext,
   input  logic [127:0] req1_key,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic         rsp0_err,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic         rsp1_err,
   output logic [127:0] rsp_data,
   output logic         core_start,
   output logic [127:0] core_plaintext,
   output logic [127:0] core_key,
   input  logic         core_done,
   input  logic [127:0] core_ciphertext,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic             owner;
   logic             last_served;
   logic             err;
   logic [CNT_W-1:0] wdog;
   logic             grant;
   logic             grant_vld;
   logic             accept;
   logic             timeout;
   logic             rsp_hs;

   // Round-robin pick: a lone requester wins; on a tie the port not served last wins.
   always_comb begin
      grant     = 1'b0;
      grant_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_served;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // Ready is gated by reset so nothing looks accepted while the block is held in reset.
   assign req0_ready = reset && (state == S_IDLE) && grant_vld && !grant;
   assign req1_ready = reset && (state == S_IDLE) && grant_vld &&  grant;
   assign accept     = req0_ready | req1_ready;
   assign timeout    = (wdog == WDOG_LAST);
   assign rsp_hs     = (state == S_RESP) && (owner ? rsp1_ready : rsp0_ready);

   assign core_start = (state == S_LAUNCH);
   assign busy       = (state != S_IDLE);
   assign rsp0_valid = (state == S_RESP) && !owner;
   assign rsp1_valid = (state == S_RESP) &&  owner;
   assign rsp0_err   = rsp0_valid && err;
   assign rsp1_err   = rsp1_valid && err;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; core_done only matters in WAIT, done wins over timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_LAUNCH;
         S_LAUNCH: state_nxt = S_WAIT;
         S_WAIT:   if (core_done || timeout) state_nxt = S_RESP;
         S_RESP:   if (rsp_hs) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Job capture, result latch and watchdog.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_plaintext <= '0;
         core_key       <= '0;
         rsp_data       <= '0;
         owner          <= 1'b0;
         last_served    <= 1'b1;
         err            <= 1'b0;
         wdog           <= '0;
      end else begin
         if (accept) begin
            core_plaintext <= grant ? req1_plaintext : req0_plaintext;
            core_key       <= grant ? req1_key       : req0_key;
            owner          <= grant;
            last_served    <= grant;
         end
         if (state == S_WAIT) begin
            wdog <= wdog + 1'b1;
            if (core_done) begin
               rsp_data <= core_ciphertext;
               err      <= 1'b0;
            end else if (timeout) begin
               rsp_data <= '0;
               err      <= 1'b1;
            end
         end else begin
            wdog <= '0;
         end
      end
   end

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Bench for aes_enc_arbiter: behavioural core stand-in plus a reference model of
// the round-robin order and expected responses.
module tb_aes_enc_arbiter;

   localparam int TO  = 64;
   localparam int LAT = 11;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [127:0] req0_plaintext = '0, req0_key = '0;
   logic [127:0] req1_plaintext = '0, req1_key = '0;
   logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [127:0] rsp_data;
   logic         core_start;
   logic [127:0] core_plaintext, core_key;
   logic         core_done = 1'b0;
   logic [127:0] core_ciphertext = '0;
   logic         busy;

   int checks = 0;
   int errors = 0;

   bit core_en = 1'b1;
   bit stray   = 1'b0;
   int cd      = 0;
   bit m_last  = 1'b1;

   logic [127:0] pt_v  [2];
   logic [127:0] key_v [2];

   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_enc_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_plaintext(req0_plaintext), .req0_key(req0_key),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_plaintext(req1_plaintext), .req1_key(req1_key),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_err(rsp1_err),
      .rsp_data(rsp_data),
      .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
      .core_done(core_done), .core_ciphertext(core_ciphertext),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Core stand-in: known FIPS-197 answers for the published vectors, a keyed mix otherwise.
   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
      if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
      if (pt == B_PT && key == B_KEY) return B_CT;
      return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Core model: done LAT cycles after a sampled start pulse; stray pulses on request.
   always @(posedge clk) begin
      core_done <= stray || (cd == 1);
      if (cd == 1) core_ciphertext <= ref_enc(core_plaintext, core_key);
      if (stray) core_ciphertext <= 128'hdead_beef_dead_beef_dead_beef_dead_beef;
      if (cd != 0) cd <= cd - 1;
      if (core_start && core_en) cd <= LAT;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reqs();
      req0_plaintext = pt_v[0];
      req0_key       = key_v[0];
      req1_plaintext = pt_v[1];
      req1_key       = key_v[1];
   endtask

   task automatic wait_rsp(input int port, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((port == 0 && rsp0_valid) || (port == 1 && rsp1_valid)) begin
            ok = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic handshake(input int port);
      if (port == 0) rsp0_ready = 1'b1;
      else rsp1_ready = 1'b1;
      step();
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) step();
      checks++;
      if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_start} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 00000000",
                  {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_start});
      end
      checks++;
      if ({rsp_data, core_plaintext, core_key} !== '0) begin
         errors++;
         $display("FAIL reset_data got %h/%h/%h exp 0", rsp_data, core_plaintext, core_key);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_busy got %b exp 0", busy);
      end
   endtask

   task automatic test_fips();
      bit ok;
      int starts;
      req0_plaintext = FIPS_PT;
      req0_key       = FIPS_KEY;
      req0_valid     = 1'b1;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         errors++;
         $display("FAIL fips_grant got %b exp 01", {req1_ready, req0_ready});
      end
      m_last = 1'b0;
      step();
      req0_valid = 1'b0;
      checks++;
      if ({core_start, busy} !== 2'b11 || core_plaintext !== FIPS_PT || core_key !== FIPS_KEY) begin
         errors++;
         $display("FAIL fips_launch got start=%b busy=%b pt=%h key=%h exp 1 1 %h %h",
                  core_start, busy, core_plaintext, core_key, FIPS_PT, FIPS_KEY);
      end
      step();
      starts = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (core_done) begin
            ok = 1'b1;
            break;
         end
         starts += int'(core_start);
         if (rsp0_valid || rsp1_valid) starts += 100;
         step();
      end
      checks++;
      if (ok !== 1'b1 || starts !== 0) begin
         errors++;
         $display("FAIL fips_wait got done=%b extra=%0d exp done=1 extra=0", ok, starts);
      end
      step();
      checks++;
      if ({rsp0_valid, rsp0_err, rsp1_valid} !== 3'b100) begin
         errors++;
         $display("FAIL fips_rsp_flags got %b exp 100", {rsp0_valid, rsp0_err, rsp1_valid});
      end
      checks++;
      if (rsp_data !== FIPS_CT) begin
         errors++;
         $display("FAIL fips_rsp_data got %h exp %h", rsp_data, FIPS_CT);
      end
      handshake(0);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL fips_idle got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int exp_p;
      logic [3:0] order;
      logic [127:0] exp_ct;
      reset = 1'b0;
      step();
      reset = 1'b1;
      m_last = 1'b1;
      pt_v[0] = FIPS_PT; key_v[0] = FIPS_KEY;
      pt_v[1] = B_PT;    key_v[1] = B_KEY;
      drive_reqs();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      order = '0;
      #1;
      for (int j = 0; j < 4; j++) begin
         exp_p = m_last ? 0 : 1;
         ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            if (req0_ready || req1_ready) begin
               ok = 1'b1;
               break;
            end
            step();
         end
         checks++;
         if ({req1_ready, req0_ready} !== (exp_p == 1 ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rr_grant job%0d got %b exp port %0d (seen=%b)", j, {req1_ready, req0_ready}, exp_p, ok);
         end
         order[j] = req1_ready;
         exp_ct = ref_enc(pt_v[exp_p], key_v[exp_p]);
         m_last = (exp_p == 1);
         step();
         pt_v[exp_p]  = rand128();
         key_v[exp_p] = rand128();
         drive_reqs();
         wait_rsp(exp_p, 100, ok);
         checks++;
         if (ok !== 1'b1 || {rsp1_valid, rsp0_valid} !== (exp_p == 1 ? 2'b10 : 2'b01) || (rsp0_err | rsp1_err) !== 1'b0) begin
            errors++;
            $display("FAIL rr_rsp job%0d got valid=%b err=%b exp port %0d err 0",
                     j, {rsp1_valid, rsp0_valid}, {rsp1_err, rsp0_err}, exp_p);
         end
         checks++;
         if (rsp_data !== exp_ct) begin
            errors++;
            $display("FAIL rr_data job%0d got %h exp %h", j, rsp_data, exp_ct);
         end
         step();
      end
      checks++;
      if (order !== 4'b1010) begin
         errors++;
         $display("FAIL rr_order got %b exp 1010", order);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      step();
   endtask

   task automatic test_hold_while_busy();
      bit ok;
      int bad;
      logic [127:0] exp0, exp1;
      pt_v[0] = rand128(); key_v[0] = rand128();
      pt_v[1] = rand128(); key_v[1] = rand128();
      drive_reqs();
      exp0 = ref_enc(pt_v[0], key_v[0]);
      exp1 = ref_enc(pt_v[1], key_v[1]);
      req0_valid = 1'b1;
      #1;
      step();
      m_last = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      bad = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (req1_ready) bad++;
         if (rsp0_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      repeat (3) begin
         step();
         if (req1_ready || !rsp0_valid) bad++;
      end
      checks++;
      if (ok !== 1'b1 || bad !== 0) begin
         errors++;
         $display("FAIL hold_busy got rsp=%b early_ready=%0d exp 1 0", ok, bad);
      end
      checks++;
      if (rsp_data !== exp0) begin
         errors++;
         $display("FAIL hold_data0 got %h exp %h", rsp_data, exp0);
      end
      rsp0_ready = 1'b1;
      #1;
      checks++;
      if (req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL hold_same_cycle got ready1=%b exp 0", req1_ready);
      end
      step();
      rsp0_ready = 1'b0;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
         errors++;
         $display("FAIL hold_next_grant got %b exp 10", {req1_ready, req0_ready});
      end
      m_last = 1'b1;
      step();
      req1_valid = 1'b0;
      wait_rsp(1, 100, ok);
      checks++;
      if (ok !== 1'b1 || rsp_data !== exp1) begin
         errors++;
         $display("FAIL hold_data1 got %h (valid=%b) exp %h", rsp_data, ok, exp1);
      end
      handshake(1);
   endtask

   task automatic test_timeout();
      bit ok;
      int bad;
      logic [127:0] exp_ct;
      core_en = 1'b0;
      req0_plaintext = rand128();
      req0_key = rand128();
      req0_valid = 1'b1;
      #1;
      step();
      req0_valid = 1'b0;
      m_last = 1'b0;
      step();
      bad = 0;
      for (int i = 0; i < TO; i++) begin
         if (rsp0_valid || !busy) bad++;
         step();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL to_early got %0d early cycles exp 0", bad);
      end
      checks++;
      if ({rsp0_valid, rsp0_err, rsp1_valid} !== 3'b110 || rsp_data !== '0) begin
         errors++;
         $display("FAIL to_rsp got flags=%b data=%h exp 110 0", {rsp0_valid, rsp0_err, rsp1_valid}, rsp_data);
      end
      stray = 1'b1;
      step();
      stray = 1'b0;
      step();
      checks++;
      if ({rsp0_valid, rsp0_err} !== 2'b11 || rsp_data !== '0) begin
         errors++;
         $display("FAIL to_stray_done got flags=%b data=%h exp 11 0", {rsp0_valid, rsp0_err}, rsp_data);
      end
      handshake(0);
      core_en = 1'b1;
      req0_plaintext = rand128();
      req0_key = rand128();
      exp_ct = ref_enc(req0_plaintext, req0_key);
      req0_valid = 1'b1;
      #1;
      step();
      req0_valid = 1'b0;
      wait_rsp(0, 100, ok);
      checks++;
      if (ok !== 1'b1 || rsp0_err !== 1'b0 || rsp_data !== exp_ct) begin
         errors++;
         $display("FAIL to_recover got valid=%b err=%b data=%h exp 1 0 %h", ok, rsp0_err, rsp_data, exp_ct);
      end
      handshake(0);
   endtask

   task automatic test_resp_stall();
      bit ok;
      int bad;
      logic [127:0] exp_ct;
      req1_plaintext = rand128();
      req1_key = rand128();
      exp_ct = ref_enc(req1_plaintext, req1_key);
      req1_valid = 1'b1;
      #1;
      step();
      m_last = 1'b1;
      req1_valid = 1'b0;
      wait_rsp(1, 100, ok);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (!rsp1_valid || rsp0_valid || rsp_data !== exp_ct || req0_ready || req1_ready || core_start) bad++;
         step();
      end
      checks++;
      if (ok !== 1'b1 || bad !== 0) begin
         errors++;
         $display("FAIL stall_stable got rsp=%b unstable=%0d exp 1 0", ok, bad);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      handshake(1);
      stray = 1'b1;
      step();
      stray = 1'b0;
      step();
      checks++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
         errors++;
         $display("FAIL stall_idle_stray got %b exp 000", {busy, rsp0_valid, rsp1_valid});
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int bad;
      logic [127:0] exp_ct;
      req0_plaintext = rand128();
      req0_key = rand128();
      req0_valid = 1'b1;
      #1;
      step();
      req0_valid = 1'b0;
      m_last = 1'b0;
      repeat (3) step();
      #2;
      reset = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({busy, core_start, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 8'h00) begin
         errors++;
         $display("FAIL rmid_ctrl got %b exp 00000000",
                  {busy, core_start, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err});
      end
      checks++;
      if ({rsp_data, core_plaintext, core_key} !== '0) begin
         errors++;
         $display("FAIL rmid_data got %h/%h/%h exp 0", rsp_data, core_plaintext, core_key);
      end
      repeat (3) step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b1;
      m_last = 1'b1;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (busy || rsp0_valid || rsp1_valid) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL rmid_late_done got %0d active cycles exp 0", bad);
      end
      pt_v[0] = rand128(); key_v[0] = rand128();
      pt_v[1] = rand128(); key_v[1] = rand128();
      drive_reqs();
      exp_ct = ref_enc(pt_v[0], key_v[0]);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== (m_last ? 2'b01 : 2'b10)) begin
         errors++;
         $display("FAIL rmid_tie got %b exp 01", {req1_ready, req0_ready});
      end
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      m_last = 1'b0;
      wait_rsp(0, 100, ok);
      checks++;
      if (ok !== 1'b1 || rsp_data !== exp_ct || rsp0_err !== 1'b0) begin
         errors++;
         $display("FAIL rmid_job got valid=%b data=%h err=%b exp 1 %h 0", ok, rsp_data, rsp0_err, exp_ct);
      end
      handshake(0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got no finish exp finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      test_reset();
      test_fips();
      test_round_robin();
      test_hold_while_busy();
      test_timeout();
      test_resp_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
